// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// 32 lines of 256 bits; a miss fetches the whole line after writing back a
// dirty victim. The pipeline is stalled while a miss is being serviced.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    localparam int LINES     = 32;
    localparam int LINE_BITS = 256;
    localparam int WORDS     = LINE_BITS / 32;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 22;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t               state_reg;
    logic [LINES-1:0]     valid_reg;
    logic [LINES-1:0]     dirty_reg;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    logic                 mem_enable_reg;
    logic                 mem_write_reg;
    logic [31:0]          mem_addr_reg;
    logic [LINE_BITS-1:0] mem_data_reg;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     addr_tag;
    logic [2:0]           word;
    logic                 hit;
    logic                 fill_we;
    logic                 store_we;
    logic [LINE_BITS-1:0] line_rd;
    logic [LINE_BITS-1:0] store_line;
    logic [31:0]          line_words [WORDS];
    logic                 unused_addr_lsb;

    // Byte offset within a word carries no information for word accesses.
    assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};

    assign addr_tag = cpu_addr_i[31:10];
    assign idx      = cpu_addr_i[9:5];
    assign word     = cpu_addr_i[4:2];
    assign line_rd  = data_mem[idx];

    assign hit      = cpu_req_i & valid_reg[idx] & (tag_mem[idx] == addr_tag);

    // Line writes: the fill happens on the memory ack, store hits only in IDLE
    // so a store that missed is applied once the refilled line hits.
    assign fill_we  = (state_reg == READMISS) & mem_ack_i;
    assign store_we = (state_reg == IDLE) & hit & cpu_we_i;

    // Split the selected line into words and build the store-merged line.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign line_words[gi]               = line_rd[gi*32 +: 32];
        assign store_line[gi*32 +: 32]      = (word == 3'(gi)) ? cpu_data_i : line_words[gi];
    end

    assign cpu_data_o   = hit ? line_words[word] : 32'd0;

    // Reset gates the stall directly so the pipeline is released the moment
    // reset asserts, even with a request pending.
    assign cpu_stall_o  = rst_i & ((state_reg != IDLE) | (cpu_req_i & ~hit));

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

    // Miss sequencer with registered memory-side outputs loaded on state entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= 32'd0;
            mem_data_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req_i & ~hit) begin
                        state_reg <= MISS;
                    end
                end
                MISS: begin
                    mem_enable_reg <= 1'b1;
                    if (valid_reg[idx] & dirty_reg[idx]) begin
                        state_reg     <= WRITEBACK;
                        mem_write_reg <= 1'b1;
                        mem_addr_reg  <= {tag_mem[idx], idx, 5'b0};
                        mem_data_reg  <= data_mem[idx];
                    end else begin
                        state_reg     <= READMISS;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= {cpu_addr_i[31:5], 5'b0};
                        mem_data_reg  <= '0;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_reg     <= READMISS;
                        mem_write_reg <= 1'b0;
                        mem_addr_reg  <= {cpu_addr_i[31:5], 5'b0};
                        mem_data_reg  <= '0;
                    end
                end
                READMISS: begin
                    if (mem_ack_i) begin
                        state_reg      <= READMISSOK;
                        mem_enable_reg <= 1'b0;
                        mem_addr_reg   <= 32'd0;
                    end
                end
                READMISSOK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg      <= IDLE;
                    mem_enable_reg <= 1'b0;
                    mem_write_reg  <= 1'b0;
                    mem_addr_reg   <= 32'd0;
                    mem_data_reg   <= '0;
                end
            endcase
        end
    end

    // Line status bits: cleared by reset, set by fills and store hits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_we) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= 1'b0;
        end else if (store_we) begin
            dirty_reg[idx] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= addr_tag;
        end else if (store_we) begin
            data_mem[idx] <= store_line;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: a line-level cache and memory model predicts every
// output on every cycle of directed and random access sequences.
module tb_dcache_ctrl;

    localparam logic [31:0] SKIP = 32'hFFFF_FFFF;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         cpu_req_i = 1'b0;
    logic         cpu_we_i = 1'b0;
    logic [31:0]  cpu_addr_i = 32'd0;
    logic [31:0]  cpu_data_i = 32'd0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int total = 0;
    int bad   = 0;
    int stall_run = 0;

    // Expected outputs for the current cycle
    logic         chk_on = 1'b1;
    logic         e_stall = 1'b0, e_en = 1'b0, e_wr = 1'b0;
    logic [31:0]  e_data = 32'd0, e_addr = 32'd0;
    logic [255:0] e_mdata = '0;

    // Hand-computed literal expectations for the current cycle
    int           lit_a_sel = 0, lit_b_sel = 0;
    logic [31:0]  lit_a_exp = 32'd0, lit_b_exp = 32'd0;

    // Cache and memory model
    logic         m_valid [32];
    logic         m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] mem_model [bit [26:0]];

    function automatic logic [255:0] mem_line(input bit [26:0] la);
        logic [255:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'(la) * 32'h9E37_79B1 + 32'(i);
        return l;
    endfunction

    function automatic logic [31:0] lit_act(input int sel);
        case (sel)
            1:       return mem_addr_o;
            2:       return mem_data_o[63:32];
            3:       return cpu_data_o;
            4:       return 32'(stall_run);
            5:       return {31'd0, mem_enable_o};
            default: return {31'd0, cpu_stall_o};
        endcase
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: all output checks happen here, away from the rising edge
    always @(negedge clk_i) begin
        if (chk_on) begin
            check("cpu_stall_o",  256'(cpu_stall_o),  256'(e_stall));
            check("cpu_data_o",   256'(cpu_data_o),   256'(e_data));
            check("mem_enable_o", 256'(mem_enable_o), 256'(e_en));
            check("mem_write_o",  256'(mem_write_o),  256'(e_wr));
            check("mem_addr_o",   256'(mem_addr_o),   256'(e_addr));
            check("mem_data_o",   mem_data_o,         e_mdata);
        end
        if (lit_a_sel != 0) check($sformatf("pin_sel%0d", lit_a_sel), 256'(lit_act(lit_a_sel)), 256'(lit_a_exp));
        if (lit_b_sel != 0) check($sformatf("pin_sel%0d", lit_b_sel), 256'(lit_act(lit_b_sel)), 256'(lit_b_exp));
        if (cpu_stall_o) stall_run++;
        else             stall_run = 0;
    end

    // One clock cycle with the given expectations
    task automatic step(input logic s, input logic en, input logic wr,
                        input logic [31:0] d, input logic [31:0] a, input logic [255:0] md);
        e_stall = s; e_en = en; e_wr = wr; e_data = d; e_addr = a; e_mdata = md;
        @(posedge clk_i); #1;
        lit_a_sel = 0;
        lit_b_sel = 0;
        mem_ack_i = 1'b0;
    endtask

    // One CPU access, walked through to its serving hit cycle
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input int wbd, input int rdd, input bit drop,
                             input logic [31:0] l_wb_addr, input logic [31:0] l_wb_w1,
                             input logic [31:0] l_rd_addr, input logic [31:0] l_fin,
                             input int l_run);
        logic [4:0]  idx;
        logic [21:0] tg;
        int          w;
        bit [26:0]   la;
        idx = addr[9:5];
        tg  = addr[31:10];
        w   = int'(addr[4:2]);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wd;
        $display("access %s addr=%h data=%h %s", we ? "ST" : "LD", addr, wd,
                 (m_valid[idx] && m_tag[idx] == tg) ? "hit" : "miss");
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            step(1, 0, 0, 0, 0, 0);
            if (drop) cpu_req_i = 1'b0;
            mem_ack_i = 1'($urandom_range(0, 1));
            step(1, 0, 0, 0, 0, 0);
            if (m_valid[idx] && m_dirty[idx]) begin
                la = {m_tag[idx], idx};
                for (int k = 0; k <= wbd; k++) begin
                    mem_ack_i = (k == wbd);
                    if (k == 0 && l_wb_addr != SKIP) begin lit_a_sel = 1; lit_a_exp = l_wb_addr; end
                    if (k == 1 && l_wb_w1 != SKIP)   begin lit_b_sel = 2; lit_b_exp = l_wb_w1; end
                    step(1, 1, 1, 0, {la, 5'b0}, m_data[idx]);
                end
                mem_model[la] = m_data[idx];
            end
            la = addr[31:5];
            mem_data_i = mem_line(la);
            for (int k = 0; k <= rdd; k++) begin
                mem_ack_i = (k == rdd);
                if (k == 0 && l_rd_addr != SKIP) begin lit_a_sel = 1; lit_a_exp = l_rd_addr; end
                step(1, 1, 0, 0, {la, 5'b0}, 0);
            end
            m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_data[idx] = mem_data_i;
            cpu_req_i = 1'b1;
            step(1, 0, 0, m_data[idx][w*32 +: 32], 0, 0);
        end
        if (l_fin != SKIP) begin lit_a_sel = 3; lit_a_exp = l_fin; end
        if (l_run >= 0)    begin lit_b_sel = 4; lit_b_exp = 32'(l_run); end
        step(0, 0, 0, m_data[idx][w*32 +: 32], 0, 0);
        if (we) begin m_data[idx][w*32 +: 32] = wd; m_dirty[idx] = 1'b1; end
        cpu_req_i = 1'b0;
    endtask

    task automatic idle_cycle();
        mem_ack_i  = 1'($urandom_range(0, 1));
        mem_data_i = {8{$urandom()}};
        cpu_we_i   = 1'($urandom_range(0, 1));
        cpu_addr_i = $urandom();
        step(0, 0, 0, 0, 0, 0);
    endtask

    logic [255:0] lit_line;
    logic [21:0]  tag_tbl [4];

    initial begin
        for (int i = 0; i < 32; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0; end
        for (int i = 0; i < 8; i++) lit_line[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        mem_model[27'h20] = lit_line;
        tag_tbl[0] = 22'h0; tag_tbl[1] = 22'h1; tag_tbl[2] = 22'h2AB; tag_tbl[3] = 22'h3F_FFFF;

        // Reset held with a request pending: all outputs stay low
        @(posedge clk_i); #1;
        cpu_req_i = 1'b1; cpu_addr_i = 32'h0000_0404;
        mem_ack_i = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        lit_a_sel = 6; lit_a_exp = 32'd0;
        step(0, 0, 0, 0, 0, 0);
        cpu_req_i = 1'b0;
        rst_i = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Cold load with a slow fill
        do_access(0, 32'h0000_0404, 0, 0, 3, 0, SKIP, SKIP, 32'h0000_0400, 32'h1000_0001, 7);
        // Store hit, spurious ack, load back
        do_access(1, 32'h0000_0404, 32'hDEAD_BEEF, 0, 0, 0, SKIP, SKIP, SKIP, SKIP, 0);
        mem_ack_i = 1'b1; mem_data_i = '1;
        step(0, 0, 0, 0, 0, 0);
        do_access(0, 32'h0000_0404, 0, 0, 0, 0, SKIP, SKIP, SKIP, 32'hDEAD_BEEF, 0);
        // Conflict miss on a dirty line
        do_access(0, 32'h0000_0804, 0, 1, 0, 0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0800, SKIP, 6);
        // Back-to-back clean misses, index 0 then 1
        do_access(0, 32'h0000_0C00, 0, 0, 0, 0, SKIP, SKIP, SKIP, SKIP, 4);
        do_access(0, 32'h0000_0C20, 0, 0, 0, 0, SKIP, SKIP, SKIP, SKIP, 4);

        // Reset in the middle of a fill
        do_access(0, 32'h0000_1060, 0, 0, 0, 0, SKIP, SKIP, SKIP, SKIP, 4);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_2060;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 32'h0000_2060, 0);
        #1 rst_i = 1'b0;
        $display("reset asserted during fill of %h", cpu_addr_i);
        lit_a_sel = 5; lit_a_exp = 32'd0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        cpu_req_i = 1'b0; rst_i = 1'b1;
        for (int i = 0; i < 32; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
        step(0, 0, 0, 0, 0, 0);
        do_access(0, 32'h0000_2060, 0, 0, 0, 0, SKIP, SKIP, 32'h0000_2060, SKIP, 4);

        // Random traffic over a few indices and tags to mix hits and conflicts
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {tag_tbl[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), a, $urandom(), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                      SKIP, SKIP, SKIP, SKIP, -1);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
